linear_sensor_readout: RTL

//  Frame sequencer for the linear photodiode array on the force sensor.

---
 rtl/linear_sensor_readout_pkg.sv | 6 +
 rtl/linear_sensor_readout.sv | 108 ++++++++++
 2 files changed

// File: rtl/linear_sensor_readout_pkg.sv
// linear_sensor_readout_pkg: sizing defaults and frame sequencer state encoding
package linear_sensor_readout_pkg;
  localparam int NPIX_DEF = 128;
  localparam int ADC_W_DEF = 12;
  typedef enum logic [2:0] {IDLE, SI_UP, CK_HI, CK_LO, TERM_HI, TERM_LO, DONE} state_e;
endpackage

// File: rtl/linear_sensor_readout.sv
// linear_sensor_readout: tick-paced SI/CLK sequencer for a linear photodiode array with per-pixel ADC capture
module linear_sensor_readout
  import linear_sensor_readout_pkg::*;
#(
  parameter int NPIX = NPIX_DEF,
  parameter int ADC_W = ADC_W_DEF,
  localparam int AW = $clog2(NPIX)
) (
  input  logic             clk_3M,
  input  logic             reset_n,
  input  logic             sensor_tick,
  input  logic             start,
  input  logic [ADC_W-1:0] adc_data,
  output logic             sensor_si,
  output logic             sensor_ck,
  output logic [ADC_W-1:0] pix_data,
  output logic [AW-1:0]    pix_addr,
  output logic             pix_valid,
  output logic             busy,
  output logic             frame_done
);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, pix_addr_q, pix_addr_d;
  logic [ADC_W-1:0] pix_data_q, pix_data_d;
  logic si_q, si_d, ck_q, ck_d, pix_valid_q, pix_valid_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic last;
  assign last = cnt_q == AW'(NPIX - 1);
  // state register
  always_ff @(posedge clk_3M or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: every phase waits for a tick except the start latch and the DONE->IDLE step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SI_UP : IDLE;
      SI_UP:   state_d = sensor_tick ? CK_HI : SI_UP;
      CK_HI:   state_d = sensor_tick ? CK_LO : CK_HI;
      CK_LO:   state_d = sensor_tick ? (last ? TERM_HI : CK_HI) : CK_LO;
      TERM_HI: state_d = sensor_tick ? TERM_LO : TERM_HI;
      TERM_LO: state_d = sensor_tick ? DONE : TERM_LO;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // output and datapath next values: pin levels, pixel capture on the falling ck tick, counter
  always_comb begin
    si_d = si_q;
    ck_d = ck_q;
    pix_data_d = pix_data_q;
    pix_addr_d = pix_addr_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    pix_valid_d = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:  busy_d = start;
      SI_UP: begin
        si_d = si_q | sensor_tick;
        ck_d = ck_q & ~sensor_tick;
      end
      CK_HI, TERM_HI: ck_d = ck_q | sensor_tick;
      CK_LO: if (sensor_tick) begin
        ck_d = 1'b0;
        si_d = 1'b0;
        pix_data_d = adc_data;
        pix_addr_d = cnt_q;
        pix_valid_d = 1'b1;
        cnt_d = last ? cnt_q : cnt_q + AW'(1);
      end
      TERM_LO: ck_d = ck_q & ~sensor_tick;
      DONE: begin
        frame_done_d = 1'b1;
        busy_d = 1'b0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end
  // output and datapath registers; reset drops everything so no partial frame completes
  always_ff @(posedge clk_3M or negedge reset_n)
    if (!reset_n) begin
      si_q <= 1'b0;
      ck_q <= 1'b0;
      pix_data_q <= '0;
      pix_addr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      pix_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      si_q <= si_d;
      ck_q <= ck_d;
      pix_data_q <= pix_data_d;
      pix_addr_q <= pix_addr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      pix_valid_q <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  assign sensor_si = si_q;
  assign sensor_ck = ck_q;
  assign pix_data = pix_data_q;
  assign pix_addr = pix_addr_q;
  assign pix_valid = pix_valid_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
endmodule
